// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - table-driven frequency-step sequencer with embedded toggle divider (optional DIV_SEQ_LOOP_EN)
module div_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DUR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [31:0]      wr_div,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW:0]      len,
    input  logic             start,
    input  logic             stop,
`ifdef DIV_SEQ_LOOP_EN
    input  logic             loop,
`endif
    output logic             div_out,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    cur_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]       state;
    logic [31:0]      tbl_div [DEPTH];
    logic [DUR_W-1:0] tbl_dur [DEPTH];
    logic [31:0]      div_reg;
    logic [DUR_W-1:0] dur_reg;
    logic [31:0]      cnt;
    logic [DUR_W-1:0] tog_cnt;
    logic [AW:0]      len_reg;
`ifdef DIV_SEQ_LOOP_EN
    logic             loop_reg;
`endif

    logic [DUR_W-1:0] dur_tgt;
    logic             last_tog;
    logic             last_idx;

    // A zero duration still plays one toggle so every entry makes progress.
    assign dur_tgt  = (dur_reg == '0) ? DUR_W'(1) : dur_reg;
    assign last_tog = ((tog_cnt + DUR_W'(1)) == dur_tgt);
    assign last_idx = ({1'b0, cur_idx} == (len_reg - (AW+1)'(1)));
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_div[i] <= '0;
                tbl_dur[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_div[wr_addr] <= wr_div;
            tbl_dur[wr_addr] <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_out  <= 1'b0;
            done     <= 1'b0;
            cur_idx  <= '0;
            div_reg  <= '0;
            dur_reg  <= '0;
            cnt      <= '0;
            tog_cnt  <= '0;
            len_reg  <= '0;
`ifdef DIV_SEQ_LOOP_EN
            loop_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= S_IDLE;
                div_out <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            div_out <= 1'b0;
                            len_reg <= len;
`ifdef DIV_SEQ_LOOP_EN
                            loop_reg <= loop;
`endif
                            if (len != '0) begin
                                state   <= S_LOAD;
                                cur_idx <= '0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        // Table is read before any same-edge write lands.
                        div_reg <= tbl_div[cur_idx];
                        dur_reg <= tbl_dur[cur_idx];
                        cnt     <= '0;
                        tog_cnt <= '0;
                        state   <= S_RUN;
                    end
                    S_RUN: begin
                        if (cnt >= div_reg) begin
                            div_out <= ~div_out;
                            cnt     <= '0;
                            tog_cnt <= tog_cnt + DUR_W'(1);
                            if (last_tog) begin
                                if (last_idx) begin
                                    done <= 1'b1;
`ifdef DIV_SEQ_LOOP_EN
                                    if (loop_reg) begin
                                        cur_idx <= '0;
                                        state   <= S_LOAD;
                                    end else begin
                                        state <= S_IDLE;
                                    end
`else
                                    state <= S_IDLE;
`endif
                                end else begin
                                    cur_idx <= cur_idx + AW'(1);
                                    state   <= S_LOAD;
                                end
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl with elapsed-time reference model
module tb_div_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DUR_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [31:0]      wr_div = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic [AW:0]      len = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
`ifdef DIV_SEQ_LOOP_EN
    logic             loop = 1'b0;
`endif
    logic             div_out;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cur_idx;

    int n_cmp = 0;
    int n_bad = 0;

    div_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DUR_W(DUR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_div(wr_div), .wr_dur(wr_dur), .len(len), .start(start), .stop(stop),
`ifdef DIV_SEQ_LOOP_EN
        .loop(loop),
`endif
        .div_out(div_out), .busy(busy), .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    // Reference model: toggle k of an entry loaded in cycle L is visible in cycle L+1+k*(div+1).
    longint t = 0;
    longint m_load = 0;
    longint m_d = 0;
    longint m_n = 1;
    longint el;
    int     m_idx = 0;
    int     m_len = 0;
    bit     m_loop = 0;
    bit     m_active = 0;
    bit     m_div = 0;
    bit     m_done = 0;
    bit     m_valid = 0;
    longint m_tdiv [DEPTH];
    longint m_tdur [DEPTH];

    always @(posedge clk) begin
        m_done = 0;
        if (!rst_n) begin
            m_active = 0;
            m_div = 0;
            m_idx = 0;
            m_valid = 1;
            for (int i = 0; i < DEPTH; i++) begin
                m_tdiv[i] = 0;
                m_tdur[i] = 0;
            end
        end else begin
            if (stop) begin
                m_active = 0;
                m_div = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_div = 0;
                    m_len = int'(len);
`ifdef DIV_SEQ_LOOP_EN
                    m_loop = loop;
`endif
                    if (len == 0) m_done = 1;
                    else begin
                        m_active = 1;
                        m_idx = 0;
                        m_load = t + 1;
                    end
                end
            end else if (t == m_load) begin
                m_d = m_tdiv[m_idx];
                m_n = (m_tdur[m_idx] == 0) ? 1 : m_tdur[m_idx];
            end else begin
                el = t - m_load;
                if (el % (m_d + 1) == 0) begin
                    m_div = ~m_div;
                    if (el / (m_d + 1) == m_n) begin
                        if (m_idx == m_len - 1) begin
                            m_done = 1;
                            if (m_loop) begin
                                m_idx = 0;
                                m_load = t + 1;
                            end else begin
                                m_active = 0;
                            end
                        end else begin
                            m_idx++;
                            m_load = t + 1;
                        end
                    end
                end
            end
            if (wr_en) begin
                m_tdiv[wr_addr] = longint'(wr_div);
                m_tdur[wr_addr] = longint'(wr_dur);
            end
        end
        t++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (div_out !== m_div || busy !== m_active || done !== m_done || cur_idx !== AW'(m_idx)) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL model t=%0d got div_out=%b busy=%b done=%b cur_idx=%0d required %b %b %b %0d",
                             t, div_out, busy, done, cur_idx, m_div, m_active, m_done, m_idx);
            end
        end
    end

    logic [16:0] tr_div, tr_busy, tr_done, tr_idx1;

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d, input int n);
        @(negedge clk);
        wr_en = 1; wr_addr = AW'(a); wr_div = 32'(d); wr_dur = DUR_W'(n);
        @(negedge clk);
        wr_en = 0;
    endtask

    // Start in cycle 0, record outputs for cycles 1..16.
    task automatic run_seq(input int l, input int stop_at, input int rst_at, input int restart_at);
        tr_div = '0; tr_busy = '0; tr_done = '0; tr_idx1 = '0;
        @(negedge clk);
        start = 1; len = (AW+1)'(l);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            tr_div[c]  = div_out;
            tr_busy[c] = busy;
            tr_done[c] = done;
            tr_idx1[c] = (cur_idx == 1);
            start = (c == restart_at);
            if (c == restart_at) len = 3;
            stop  = (c == stop_at);
            rst_n = !(c == rst_at);
        end
        start = 0; stop = 0; rst_n = 1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;

        wr(0, 2, 4);
        run_seq(1, -1, -1, -1);
        chk("s1_div",  tr_div,  17'b00011100011100000);
        chk("s1_busy", tr_busy, 17'b00011111111111110);
        chk("s1_done", tr_done, 17'b00100000000000000);
        chk("s1_idx",  tr_idx1, 17'b00000000000000000);

        wr(0, 0, 2);
        wr(1, 1, 1);
        run_seq(2, -1, -1, -1);
        chk("s2_div",  tr_div,  17'b11111111110001000);
        chk("s2_busy", tr_busy, 17'b00000000001111110);
        chk("s2_done", tr_done, 17'b00000000010000000);
        chk("s2_idx",  tr_idx1, 17'b11111111111110000);

        wr(0, 5, 10);
        run_seq(1, 8, -1, -1);
        chk("s3_div",  tr_div,  17'b00000000100000000);
        chk("s3_busy", tr_busy, 17'b00000000111111110);
        chk("s3_done", tr_done, 17'b00000000000000000);

        run_seq(0, -1, -1, -1);
        chk("s4_busy", tr_busy, 17'b00000000000000000);
        chk("s4_done", tr_done, 17'b00000000000000010);

        wr(0, 1, 0);
        run_seq(1, -1, -1, -1);
        chk("s5_div",  tr_div,  17'b11111111111110000);
        chk("s5_busy", tr_busy, 17'b00000000000001110);
        chk("s5_done", tr_done, 17'b00000000000010000);

        wr(0, 2, 4);
        run_seq(1, -1, -1, 6);
        chk("s6_div",  tr_div,  17'b00011100011100000);
        chk("s6_busy", tr_busy, 17'b00011111111111110);
        chk("s6_done", tr_done, 17'b00100000000000000);

        run_seq(1, -1, 6, -1);
        chk("s7_div",  tr_div,  17'b00000000001100000);
        chk("s7_busy", tr_busy, 17'b00000000001111110);
        chk("s7_done", tr_done, 17'b00000000000000000);

        run_seq(1, -1, -1, -1);
        chk("s8_div",  tr_div,  17'b11111111111111000);
        chk("s8_busy", tr_busy, 17'b00000000000000110);
        chk("s8_done", tr_done, 17'b00000000000001000);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_div  = 32'($urandom_range(0, 4));
            wr_dur  = DUR_W'($urandom_range(0, 4));
            len     = (AW+1)'($urandom_range(0, DEPTH));
            start   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
`ifdef DIV_SEQ_LOOP_EN
            loop    = 1'($urandom_range(0, 1));
`endif
        end
        @(negedge clk);
        wr_en = 0; start = 0; stop = 0; rst_n = 1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
